// File: rtl/sand_sweep.sv
// Frame sweep sequencer: walks region/floor word pairs bottom-up, feeds them to
// sand_update and writes back only the words the physics step changed.
module sand_sweep #(
    parameter int unsigned WORDS_PER_ROW = 40,
    parameter int unsigned ROWS          = 480,
    parameter int unsigned ADDR_W        = 15
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              mem_req,
    input  logic              mem_gnt,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata,
    output logic [31:0]       phys_region,
    output logic [31:0]       phys_floor,
    output logic              phys_screenbegin,
    output logic              phys_screenend,
    output logic              phys_screenbottom,
    input  logic [31:0]       phys_new_region,
    input  logic [31:0]       phys_new_floor
);

    localparam int unsigned COL_W = (WORDS_PER_ROW > 1) ? $clog2(WORDS_PER_ROW) : 1;
    localparam int unsigned ROW_W = $clog2(ROWS);

    localparam logic [ADDR_W-1:0] START_ADDR = ADDR_W'((ROWS - 2) * WORDS_PER_ROW);
    localparam logic [ADDR_W-1:0] ROW_STRIDE = ADDR_W'(WORDS_PER_ROW);
    localparam logic [ADDR_W-1:0] ROW_BACK   = ADDR_W'(2 * WORDS_PER_ROW - 1);
    localparam logic [COL_W-1:0]  COL_LAST   = COL_W'(WORDS_PER_ROW - 1);
    localparam logic [ROW_W-1:0]  ROW_FIRST  = ROW_W'(ROWS - 2);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD_R,
        S_WAIT_R,
        S_RD_F,
        S_WAIT_F,
        S_WR_R,
        S_WR_F,
        S_DONE
    } state_t;

    state_t            r_state;
    logic [ADDR_W-1:0] r_raddr;
    logic [COL_W-1:0]  r_col;
    logic [ROW_W-1:0]  r_row;
    logic [31:0]       r_region;
    logic [31:0]       r_floor;
    logic              r_busy;
    logic              r_done;
    logic              r_sbegin;
    logic              r_send;
    logic              r_sbot;

    logic [ADDR_W-1:0] w_faddr;
    logic              w_region_dirty;
    logic              w_floor_dirty;
    logic              w_req;
    logic              w_we;
    logic [ADDR_W-1:0] w_addr;
    logic [31:0]       w_wdata;
    logic              w_adv;
    logic [COL_W-1:0]  w_col_next;

    assign w_faddr        = r_raddr + ROW_STRIDE;
    assign w_region_dirty = (phys_new_region != r_region);
    assign w_floor_dirty  = (phys_new_floor != r_floor);
    assign w_col_next     = r_col + COL_W'(1);

    // Memory request decode; write decisions need the live physics result.
    always_comb begin
        w_req   = 1'b0;
        w_we    = 1'b0;
        w_addr  = '0;
        w_wdata = '0;
        case (r_state)
            S_RD_R: begin
                w_req  = 1'b1;
                w_addr = r_raddr;
            end
            S_RD_F: begin
                w_req  = 1'b1;
                w_addr = w_faddr;
            end
            S_WR_R: begin
                if (w_region_dirty) begin
                    w_req   = 1'b1;
                    w_we    = 1'b1;
                    w_addr  = r_raddr;
                    w_wdata = phys_new_region;
                end
            end
            S_WR_F: begin
                if (w_floor_dirty) begin
                    w_req   = 1'b1;
                    w_we    = 1'b1;
                    w_addr  = w_faddr;
                    w_wdata = phys_new_floor;
                end
            end
            default: ;
        endcase
    end

    // A skipped write advances immediately; a real access waits for grant.
    assign w_adv = !w_req || mem_gnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_raddr  <= '0;
            r_col    <= '0;
            r_row    <= '0;
            r_region <= '0;
            r_floor  <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_sbegin <= 1'b0;
            r_send   <= 1'b0;
            r_sbot   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_state  <= S_RD_R;
                        r_busy   <= 1'b1;
                        r_raddr  <= START_ADDR;
                        r_col    <= '0;
                        r_row    <= ROW_FIRST;
                        r_sbegin <= 1'b1;
                        r_send   <= (COL_LAST == '0);
                        r_sbot   <= 1'b1;
                    end
                end
                S_RD_R: begin
                    if (mem_gnt) r_state <= S_WAIT_R;
                end
                S_WAIT_R: begin
                    r_region <= mem_rdata;
                    r_state  <= S_RD_F;
                end
                S_RD_F: begin
                    if (mem_gnt) r_state <= S_WAIT_F;
                end
                S_WAIT_F: begin
                    r_floor <= mem_rdata;
                    r_state <= S_WR_R;
                end
                S_WR_R: begin
                    if (w_adv) r_state <= S_WR_F;
                end
                S_WR_F: begin
                    if (w_adv) begin
                        if (r_col != COL_LAST) begin
                            r_state  <= S_RD_R;
                            r_col    <= w_col_next;
                            r_raddr  <= r_raddr + ADDR_W'(1);
                            r_sbegin <= 1'b0;
                            r_send   <= (w_col_next == COL_LAST);
                        end else if (r_row != '0) begin
                            // Jump to column 0 of the row above.
                            r_state  <= S_RD_R;
                            r_col    <= '0;
                            r_row    <= r_row - ROW_W'(1);
                            r_raddr  <= r_raddr - ROW_BACK;
                            r_sbegin <= 1'b1;
                            r_send   <= (COL_LAST == '0);
                            r_sbot   <= 1'b0;
                        end else begin
                            r_state  <= S_DONE;
                            r_done   <= 1'b1;
                            r_sbegin <= 1'b0;
                            r_send   <= 1'b0;
                            r_sbot   <= 1'b0;
                        end
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign busy              = r_busy;
    assign done              = r_done;
    assign mem_req           = w_req;
    assign mem_we            = w_we;
    assign mem_addr          = w_addr;
    assign mem_wdata         = w_wdata;
    assign phys_region       = r_region;
    assign phys_floor        = r_floor;
    assign phys_screenbegin  = r_sbegin;
    assign phys_screenend    = r_send;
    assign phys_screenbottom = r_sbot;

endmodule

// File: tb/tb_sand_sweep.sv
// Bench for sand_sweep on a 2x4-word playfield with a simple falling-grain physics stub.
module tb_sand_sweep;

    localparam int unsigned WPR    = 2;
    localparam int unsigned ROWS   = 4;
    localparam int unsigned ADDR_W = 4;
    localparam int unsigned NW     = WPR * ROWS;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              start = 1'b0;
    logic              busy, done, mem_req, mem_we;
    logic              mem_gnt = 1'b1;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic [31:0]       mem_rdata = '0;
    logic [31:0]       phys_region, phys_floor;
    logic              phys_screenbegin, phys_screenend, phys_screenbottom;
    logic [31:0]       phys_new_region, phys_new_floor;

    always #5 clk = ~clk;

    sand_sweep #(.WORDS_PER_ROW(WPR), .ROWS(ROWS), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .reset(reset), .start(start), .busy(busy), .done(done),
        .mem_req(mem_req), .mem_gnt(mem_gnt), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .phys_region(phys_region), .phys_floor(phys_floor),
        .phys_screenbegin(phys_screenbegin), .phys_screenend(phys_screenend),
        .phys_screenbottom(phys_screenbottom),
        .phys_new_region(phys_new_region), .phys_new_floor(phys_new_floor)
    );

    // Physics stub: a SAND pixel (01) over AIR (00) drops and lands as 10.
    function automatic logic [63:0] phys_step(input logic [31:0] r, input logic [31:0] f);
        logic [31:0] nr, nf;
        nr = r;
        nf = f;
        for (int p = 0; p < 16; p++) begin
            if (r[2*p +: 2] == 2'b01 && f[2*p +: 2] == 2'b00) begin
                nr[2*p +: 2] = 2'b00;
                nf[2*p +: 2] = 2'b10;
            end
        end
        return {nr, nf};
    endfunction

    assign {phys_new_region, phys_new_floor} = phys_step(phys_region, phys_floor);

    typedef struct {
        logic        we;
        int          addr;
        logic [31:0] data;
        logic        sbegin;
    } txn_t;

    logic [31:0] mem      [16];
    logic [31:0] init_mem [16];
    logic [31:0] model_mem[16];
    txn_t        obs_q[$];
    txn_t        exp_q[$];

    int gnt_mode = 0;
    int stall_addr = 0;
    int stall_target = 0;
    int stall_cnt = 0;
    int n_checks = 0;
    int n_err = 0;

    // Frame-buffer model: loads from init_mem during reset, logs every granted access.
    always @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 16; i++) mem[i] <= init_mem[i];
            obs_q.delete();
        end else if (mem_req && mem_gnt) begin
            if (mem_we) mem[mem_addr] <= mem_wdata;
            else        mem_rdata <= mem[mem_addr];
            obs_q.push_back('{mem_we, int'(mem_addr), mem_wdata, phys_screenbegin});
        end
    end

    // Grant generator: tied high, random, or a bounded stall on one read address.
    always @(negedge clk) begin
        if (reset) stall_cnt = 0;
        case (gnt_mode)
            0: mem_gnt = 1'b1;
            1: mem_gnt = ($urandom_range(0, 3) != 0);
            default: begin
                if (mem_req && !mem_we && int'(mem_addr) == stall_addr && stall_cnt < stall_target) begin
                    mem_gnt = 1'b0;
                    stall_cnt++;
                end else begin
                    mem_gnt = 1'b1;
                end
            end
        endcase
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        tick();
    endtask

    // Reference sweep: row ROWS-2 up to 0, column 0 up, write back only changed words.
    task automatic build_expected();
        logic [63:0] res;
        int a, fa;
        for (int i = 0; i < 16; i++) model_mem[i] = init_mem[i];
        exp_q.delete();
        for (int row = ROWS - 2; row >= 0; row--) begin
            for (int col = 0; col < WPR; col++) begin
                a  = row * WPR + col;
                fa = a + WPR;
                exp_q.push_back('{1'b0, a, 32'h0, 1'b0});
                exp_q.push_back('{1'b0, fa, 32'h0, 1'b0});
                res = phys_step(model_mem[a], model_mem[fa]);
                if (res[63:32] != model_mem[a]) begin
                    exp_q.push_back('{1'b1, a, res[63:32], 1'b0});
                    model_mem[a] = res[63:32];
                end
                if (res[31:0] != model_mem[fa]) begin
                    exp_q.push_back('{1'b1, fa, res[31:0], 1'b0});
                    model_mem[fa] = res[31:0];
                end
            end
        end
    endtask

    task automatic check_txns(input string name);
        int n;
        logic ok;
        check({name, "_count"}, 32'(obs_q.size()), 32'(exp_q.size()));
        n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) begin
            ok = (obs_q[i].we == exp_q[i].we) && (obs_q[i].addr == exp_q[i].addr) &&
                 (!exp_q[i].we || obs_q[i].data == exp_q[i].data);
            n_checks++;
            if (!ok) begin
                n_err++;
                $display("FAIL %s[%0d]: got we=%0b addr=%0d data=%h expected we=%0b addr=%0d data=%h",
                         name, i, obs_q[i].we, obs_q[i].addr, obs_q[i].data,
                         exp_q[i].we, exp_q[i].addr, exp_q[i].data);
            end
        end
    endtask

    task automatic check_mem(input string name);
        for (int i = 0; i < NW; i++) check($sformatf("%s_mem%0d", name, i), mem[i], model_mem[i]);
    endtask

    task automatic run_until_done(input int c0, input int bound, output int done_c);
        int c;
        c = c0;
        while (!done && c < bound) begin
            tick();
            c++;
        end
        check("done_reached", 32'(done), 32'd1);
        done_c = c;
    endtask

    typedef struct {
        logic       chk_mem;
        logic       req;
        logic       we;
        logic [3:0] addr;
        logic       busy;
        logic       done;
        logic       chk_flags;
        logic       sbegin;
        logic       send;
        logic       sbot;
    } vec_t;

    vec_t vec[41];
    int   rd_r[6] = '{4, 5, 2, 3, 0, 1};
    int   rd_f[6] = '{6, 7, 4, 5, 2, 3};

    initial begin
        int k, p, dc, done_cnt;
        logic [31:0] v;

        // All-AIR sweep timeline, indexed by cycle after the start edge.
        for (int c = 0; c <= 40; c++) begin
            vec[c] = '{1'b1, 1'b0, 1'b0, 4'd0, (c >= 1 && c <= 37), (c == 37), 1'b0, 1'b0, 1'b0, 1'b0};
            if (c >= 1 && c <= 36) begin
                k = (c - 1) / 6;
                p = (c - 1) % 6;
                vec[c].req  = (p == 0 || p == 2);
                vec[c].addr = 4'((p == 0) ? rd_r[k] : rd_f[k]);
                if (p == 3 || p == 5) begin
                    vec[c].chk_flags = 1'b1;
                    vec[c].sbegin    = (k % 2 == 0);
                    vec[c].send      = (k % 2 == 1);
                    vec[c].sbot      = (k < 2);
                end
            end
        end

        for (int i = 0; i < 16; i++) init_mem[i] = '0;
        tick();
        tick();
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_req", 32'(mem_req), 32'd0);
        check("rst_we", 32'(mem_we), 32'd0);
        check("rst_addr", 32'(mem_addr), 32'd0);
        check("rst_wdata", mem_wdata, 32'd0);
        check("rst_region", phys_region, 32'd0);
        check("rst_floor", phys_floor, 32'd0);
        check("rst_flags", {29'd0, phys_screenbegin, phys_screenend, phys_screenbottom}, 32'd0);
        reset = 1'b0;
        tick();

        // All-AIR sweep: address order, busy/done window, flag decode.
        build_expected();
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 1; c <= 40; c++) begin
            if (vec[c].chk_mem) begin
                check($sformatf("air_req_c%0d", c), 32'(mem_req), 32'(vec[c].req));
                if (vec[c].req) begin
                    check($sformatf("air_we_c%0d", c), 32'(mem_we), 32'(vec[c].we));
                    check($sformatf("air_addr_c%0d", c), 32'(mem_addr), 32'(vec[c].addr));
                end
            end
            check($sformatf("air_busy_c%0d", c), 32'(busy), 32'(vec[c].busy));
            check($sformatf("air_done_c%0d", c), 32'(done), 32'(vec[c].done));
            if (vec[c].chk_flags)
                check($sformatf("air_flags_c%0d", c),
                      {29'd0, phys_screenbegin, phys_screenend, phys_screenbottom},
                      {29'd0, vec[c].sbegin, vec[c].send, vec[c].sbot});
            tick();
        end
        check_txns("air_txn");

        // Single grain in row 0 word 0 falls into word 2.
        init_mem[0] = 32'h4000_0000;
        build_expected();
        do_reset();
        start = 1'b1;
        tick();
        start = 1'b0;
        run_until_done(1, 300, dc);
        tick();
        check_txns("grain_txn");
        check_mem("grain");
        for (int i = 0; i < obs_q.size(); i++) begin
            if (obs_q[i].we) begin
                check($sformatf("grain_wr_addr%0d_data", obs_q[i].addr), obs_q[i].data,
                      (obs_q[i].addr == 2) ? 32'h8000_0000 : 32'h0);
                check($sformatf("grain_wr_addr%0d_sbegin", obs_q[i].addr), 32'(obs_q[i].sbegin), 32'd1);
            end
        end
        check("grain_final0", mem[0], 32'h0);
        check("grain_final2", mem[2], 32'h8000_0000);

        // Five-cycle grant stall on the first floor read.
        for (int i = 0; i < 16; i++) init_mem[i] = '0;
        init_mem[6]  = 32'h1234_5678;
        gnt_mode     = 2;
        stall_addr   = 6;
        stall_target = 5;
        build_expected();
        do_reset();
        start = 1'b1;
        tick();
        start = 1'b0;
        dc = -1;
        for (int c = 1; c < 120; c++) begin
            if (c >= 3 && c <= 7) begin
                check($sformatf("stall_req_c%0d", c), 32'(mem_req), 32'd1);
                check($sformatf("stall_addr_c%0d", c), 32'(mem_addr), 32'd6);
            end
            if (c == 10) check("stall_floor", phys_floor, 32'h1234_5678);
            if (done) begin
                dc = c;
                break;
            end
            tick();
        end
        check("stall_done_cycle", 32'(dc), 32'd42);
        tick();
        check_txns("stall_txn");
        gnt_mode = 0;

        // Reset during the first WR_R, then a clean restart.
        for (int i = 0; i < 16; i++) init_mem[i] = '0;
        do_reset();
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 1; c < 5; c++) tick();
        reset = 1'b1;
        tick();
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_req", 32'(mem_req), 32'd0);
        reset = 1'b0;
        tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        check("restart_req", 32'(mem_req), 32'd1);
        check("restart_we", 32'(mem_we), 32'd0);
        check("restart_addr", 32'(mem_addr), 32'd4);
        run_until_done(1, 300, dc);
        check("restart_done_cycle", 32'(dc), 32'd37);
        tick();

        // Start pulses during the sweep and during DONE are ignored.
        do_reset();
        start = 1'b1;
        tick();
        start = 1'b0;
        done_cnt = 0;
        dc = -1;
        for (int c = 1; c <= 60; c++) begin
            if (done) begin
                done_cnt++;
                dc = c;
            end
            if (c == 45) begin
                check("ign_busy_after", 32'(busy), 32'd0);
                check("ign_req_after", 32'(mem_req), 32'd0);
            end
            start = (c == 10 || c == 37);
            tick();
            start = 1'b0;
        end
        check("ign_done_count", 32'(done_cnt), 32'd1);
        check("ign_done_cycle", 32'(dc), 32'd37);

        // Random playfields under random grant stalls.
        gnt_mode = 1;
        for (int it = 0; it < 4; it++) begin
            for (int i = 0; i < 16; i++) begin
                v = $urandom;
                init_mem[i] = (i < NW) ? v : 32'h0;
            end
            build_expected();
            do_reset();
            start = 1'b1;
            tick();
            start = 1'b0;
            run_until_done(1, 2000, dc);
            tick();
            check($sformatf("rnd%0d_busy_end", it), 32'(busy), 32'd0);
            check_txns($sformatf("rnd%0d_txn", it));
            check_mem($sformatf("rnd%0d", it));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule

// File: doc/sand_sweep.md
# sand_sweep

Frame-level sequencer that drives one combinational `sand_update` instance against the frame-buffer RAM. On each `start` pulse it walks the playfield from the second-to-last row up to row 0. For every 32-bit word (16 pixels × 2 bits) it reads the region word and the floor word directly below. It presents both to the physics block, then writes the updated words back. It sits between the frame-tick logic and the shared frame-buffer port, and arbitrates for that port through a request/grant handshake.

## Interface
Parameters:
- `WORDS_PER_ROW`, 40: 32-bit words per screen row (640 px / 16).
- `ROWS`, 480: screen rows; must be ≥ 2.
- `ADDR_W`, 15: frame-buffer word-address width; must satisfy ROWS×WORDS_PER_ROW ≤ 2^ADDR_W.

Ports:
- `clk`, in, 1: single clock. Reset is synchronous and active-high.
- `reset`, in, 1: synchronous, active-high.
- `start`, in, 1: one-cycle pulse that begins a sweep; ignored while busy.
- `busy`, out, 1: sweep in progress.
- `done`, out, 1: one-cycle pulse at the end of a sweep.
- `mem_req`, out, 1: access request; held until granted.
- `mem_gnt`, in, 1: access performed in a cycle with `mem_req` && `mem_gnt`.
- `mem_we`, out, 1: 1 = write, 0 = read; valid with `mem_req`.
- `mem_addr`, out, ADDR_W: word address.
- `mem_wdata`, out, 32: write data.
- `mem_rdata`, in, 32: read data, valid the cycle after a granted read.
- `phys_region`, out, 32: region word to `sand_update`.
- `phys_floor`, out, 32: floor word to `sand_update`.
- `phys_screenbegin`, out, 1: current word is column 0.
- `phys_screenend`, out, 1: current word is column WORDS_PER_ROW-1.
- `phys_screenbottom`, out, 1: region row == ROWS-2.
- `phys_new_region`, in, 32: `sand_update` result for the region word.
- `phys_new_floor`, in, 32: `sand_update` result for the floor word.

## Operation
- **States and transitions:**
  - IDLE → RD_R on `start`.
  - RD_R → WAIT_R → RD_F → WAIT_F → WR_R → WR_F.
  - WR_F → RD_R for the next word, or WR_F → DONE after the last word.
  - DONE → IDLE.
- **Address counters:**
  - `raddr` starts at (ROWS-2)×WORDS_PER_ROW. Floor address = `raddr` + WORDS_PER_ROW.
  - `col` is a column counter; `row` is a row counter starting at ROWS-2.
- **RD_R:** `mem_req`=1, `mem_we`=0, `mem_addr`=`raddr`. Advance on grant.
- **WAIT_R:** capture `mem_rdata` into the region register, unconditionally, for one cycle.
- **RD_F:** `mem_req`=1, `mem_we`=0, `mem_addr`=`raddr`+WORDS_PER_ROW. Advance on grant.
- **WAIT_F:** capture `mem_rdata` into the floor register.
- **WR_R:**
  - If `phys_new_region` ≠ region register: `mem_req`=1, `mem_we`=1, `mem_addr`=`raddr`, `mem_wdata`=`phys_new_region`. Advance on grant.
  - Otherwise issue no request and advance in one cycle.
- **WR_F:** same rule using `phys_new_floor` vs the floor register, at address `raddr`+WORDS_PER_ROW.
- **Counter advance on leaving WR_F:**
  - If `col` < WORDS_PER_ROW-1: `col`++ and `raddr`++.
  - Else, if `row` > 0: `col`=0, `row`--, `raddr` = `raddr` − 2×WORDS_PER_ROW + 1.
  - Else go to DONE.
- **Physics outputs:** `phys_region` and `phys_floor` come directly from the capture registers. The `phys_screen*` flags are decoded from registered `col`/`row`. All of these are stable from WAIT_F through the end of WR_F.
- **Coverage:** row ROWS-1 is never a region word. Row 0 is the last region row.
- **Simultaneous events:**
  - `start` during busy (including DONE) is ignored.
  - `start` and `reset` together: reset wins.
- **Reset (any state, including mid-sweep):** go to IDLE and clear counters. Partially processed words are not restored.

## Timing
- **Reset values:** `busy`=0, `done`=0, `mem_req`=0, `mem_we`=0, `mem_addr`=0, `mem_wdata`=0, `phys_region`=0, `phys_floor`=0, all `phys_screen*`=0.
- **Start to first request:** `start` sampled in cycle t; RD_R with `mem_req`=1 in t+1.
- **Busy window:** `busy` = (state ≠ IDLE). It is high from t+1 through the DONE cycle.
- **Done:** `done`=1 only in the DONE cycle.
- **Stalls:** while `mem_gnt`=0, the state and every memory output hold. There is no limit on stall length.
- **Per-word cost with `mem_gnt` tied high:** exactly 6 cycles, whether or not writes are skipped.
- **Sweep length with `mem_gnt` tied high:**
  - 6×WORDS_PER_ROW×(ROWS-1) word cycles, then DONE.
  - `done` asserts at t+6×WORDS_PER_ROW×(ROWS-1)+1.
- **Write-after-read ordering:** a WR_R write to address A always follows the read of A within the same word. Floor writes land before the next row up reads that word as its floor.

## Test plan
- **Address order and done timing:** WORDS_PER_ROW=2, ROWS=4, `mem_gnt`=1, all-AIR memory, `start` at cycle 0.
  - Read addresses in order: 4,6,5,7,2,4,3,5,0,2,1,3.
  - No writes.
  - `done` high in cycle 37 only; `busy` high in cycles 1–37.
- **Single sand grain:** word 0 = 32'h4000_0000 (pixel 15 = SAND), word 2 = 0, same parameters.
  - During the row-0 word-0 pass, write addr 0 ← 0 and addr 2 ← 32'h8000_0000.
  - `phys_screenbegin`=1 during that pass.
- **Grant stall:** `mem_gnt` held low for 5 cycles during RD_F.
  - `mem_addr` and `mem_req` stay constant throughout.
  - Captured floor equals the memory word.
  - Total sweep is exactly 5 cycles longer.
- **Flag decode:** `phys_screenend`=1 only for col 1; `phys_screenbottom`=1 only while `row`=2.
- **Reset mid-sweep:** `reset` asserted in a WR_R cycle.
  - Next cycle: `busy`=0, `mem_req`=0.
  - A subsequent `start` restarts at address 4.
- **Start ignored while busy:** `start` pulsed during a sweep and again during DONE.
  - No restart occurs; exactly one `done` pulse.
